// File: rtl/msk_encode_pipe_pkg.sv
// Shared encode helpers for the masking pipeline: share indexing plus trivial
// and randomised Boolean sharing of a public word.
package msk_pkg;

    localparam int MAX_W = 128;

    typedef logic [$clog2(MAX_W)-1:0] idx_t;

    function automatic idx_t share_bit(input int i, input int j, input int d);
        return idx_t'(i * d + j);
    endfunction

    function automatic logic [MAX_W-1:0] msk_encode_trivial(
        input logic [MAX_W-1:0] cst,
        input int               d,
        input int               count
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < count; i++) begin
            r[share_bit(i, d - 1, d)] = cst[idx_t'(i)];
        end
        return r;
    endfunction

    // The last share absorbs the parity of the random shares so each group still XORs to cst[i].
    function automatic logic [MAX_W-1:0] msk_encode_rand(
        input logic [MAX_W-1:0] cst,
        input logic [MAX_W-1:0] rnd,
        input int               d,
        input int               count
    );
        logic [MAX_W-1:0] r;
        logic             acc;
        r = '0;
        for (int i = 0; i < count; i++) begin
            acc = cst[idx_t'(i)];
            for (int j = 0; j < d - 1; j++) begin
                r[share_bit(i, j, d)] = rnd[idx_t'(i * (d - 1) + j)];
                acc = acc ^ rnd[idx_t'(i * (d - 1) + j)];
            end
            r[share_bit(i, d - 1, d)] = acc;
        end
        return r;
    endfunction

endpackage

// File: rtl/msk_encode_pipe_if.sv
// Valid/ready bundle between the public word/randomness sources, the encoder
// and the masked datapath; master is the environment side, slave the encoder.
interface msk_encode_pipe_if #(
    parameter int d     = 2,
    parameter int count = 1
);
    localparam int RW = (count * (d - 1) > 0) ? count * (d - 1) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [count-1:0]     cst;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic [RW-1:0]        rnd;
    logic                 out_valid;
    logic                 out_ready;
    logic [count*d-1:0]   out;

    modport master (
        output in_valid, cst, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out
    );

    modport slave (
        input  in_valid, cst, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out
    );

endinterface

// File: rtl/msk_encode_pipe_fifo2.sv
// Two-entry valid/ready buffer; keeps one word per cycle flowing while the
// output side stalls for a cycle, and never exposes unregistered data.
module msk_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_occ;
    logic             w_doPush;
    logic             w_doPop;

    // A full buffer refuses pushes even when the head leaves in the same cycle.
    assign w_doPush = i_push && (r_occ != 2'd2);
    assign w_doPop  = i_pop  && (r_occ != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (w_doPop) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + 2'(w_doPush) - 2'(w_doPop);
        end
    end

    assign o_full  = (r_occ == 2'd2);
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_head];

endmodule

// File: rtl/msk_encode_pipe.sv
// Registered encoder turning a public word into a d-share Boolean sharing,
// trivially or with fresh randomness, behind a two-entry output buffer.
module msk_encode_pipe
    import msk_pkg::*;
#(
    parameter int d         = 2,
    parameter int count     = 1,
    parameter bit RANDOMIZE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    msk_encode_pipe_if.slave bus
);

    localparam int W          = count * d;
    localparam bit RND_NEEDED = RANDOMIZE && (d > 1);

    if (W > MAX_W) begin : g_widthGuard
        $error("msk_encode_pipe: count*d exceeds msk_pkg::MAX_W");
    end

    logic [W-1:0] w_encoded;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    always_comb begin
        if (RND_NEEDED) begin
            w_encoded = W'(msk_encode_rand(MAX_W'(bus.cst), MAX_W'(bus.rnd), d, count));
        end else begin
            w_encoded = W'(msk_encode_trivial(MAX_W'(bus.cst), d, count));
        end
    end

    // Acceptance depends only on buffer space and randomness, never on out_ready.
    assign bus.in_ready  = !w_full && (bus.rnd_valid || !RND_NEEDED);
    assign bus.rnd_ready = RND_NEEDED && bus.in_valid && !w_full;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    msk_fifo2 #(
        .WIDTH (W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_encoded),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (bus.out_valid),
        .o_data  (bus.out)
    );

endmodule

// File: tb/tb_msk_encode_pipe.sv
// Bench for msk_encode_pipe: random (d=2), trivial (d=2) and single-share (d=1)
// instances checked by a vector table, hand sequences and output scoreboards.
module tb_msk_encode_pipe;

    typedef struct {
        logic [3:0] cst;
        logic [3:0] rnd;
        logic [7:0] expRand;
        logic [7:0] expTriv;
    } vector_t;

    logic clk;
    logic rst_n;
    int   vecCount;
    int   missCount;

    logic [7:0] qA [$];
    logic [7:0] qC [$];

    vector_t    vectors [5];
    logic [3:0] r0, r1, r2;
    logic [7:0] cWord;
    bit         sent;

    msk_encode_pipe_if #(.d(2), .count(4)) ifA ();
    msk_encode_pipe_if #(.d(2), .count(4)) ifB ();
    msk_encode_pipe_if #(.d(1), .count(8)) ifC ();

    msk_encode_pipe #(.d(2), .count(4), .RANDOMIZE(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    msk_encode_pipe #(.d(2), .count(4), .RANDOMIZE(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
    msk_encode_pipe #(.d(1), .count(8), .RANDOMIZE(1'b1)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random two-share model: share0 is the random bit, share1 restores the parity.
    function automatic logic [7:0] modelA(input logic [3:0] c, input logic [3:0] r);
        logic [7:0] o;
        for (int i = 0; i < 4; i++) begin
            o[2*i]     = r[i];
            o[2*i + 1] = c[i] ^ r[i];
        end
        return o;
    endfunction

    function automatic logic [3:0] foldShares(input logic [7:0] o);
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = o[2*i] ^ o[2*i + 1];
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vector_t v);
        ifA.cst = v.cst; ifA.rnd = v.rnd; ifA.in_valid = 1'b1; ifA.rnd_valid = 1'b1; ifA.out_ready = 1'b1;
        ifB.cst = v.cst; ifB.rnd = v.rnd; ifB.in_valid = 1'b1; ifB.rnd_valid = 1'b1; ifB.out_ready = 1'b1;
        #1;
        checkOutput("tbl_a_in_ready", 64'(ifA.in_ready), 64'd1);
        checkOutput("tbl_a_rnd_ready", 64'(ifA.rnd_ready), 64'd1);
        checkOutput("tbl_b_rnd_ready", 64'(ifB.rnd_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("tbl_a_valid", 64'(ifA.out_valid), 64'd1);
        checkOutput("tbl_a_out", 64'(ifA.out), 64'(v.expRand));
        checkOutput("tbl_a_fold", 64'(foldShares(ifA.out)), 64'(v.cst));
        checkOutput("tbl_b_valid", 64'(ifB.out_valid), 64'd1);
        checkOutput("tbl_b_out", 64'(ifB.out), 64'(v.expTriv));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Transfers are decided on the falling edge, half a cycle before the edge that commits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifA.out_valid && ifA.out_ready) begin
                checkOutput("sb_a_avail", 64'(qA.size() != 0), 64'd1);
                if (qA.size() != 0) checkOutput("sb_a_word", 64'(ifA.out), 64'(qA.pop_front()));
            end
            if (ifA.in_valid && ifA.in_ready) qA.push_back(modelA(ifA.cst, ifA.rnd));
            if (ifC.out_valid && ifC.out_ready) begin
                checkOutput("sb_c_avail", 64'(qC.size() != 0), 64'd1);
                if (qC.size() != 0) checkOutput("sb_c_word", 64'(ifC.out), 64'(qC.pop_front()));
            end
            if (ifC.in_valid && ifC.in_ready) qC.push_back(ifC.cst);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecCount  = 0;
        missCount = 0;
        vectors[0] = '{4'hA, 4'h6, 8'hB4, 8'h88};
        vectors[1] = '{4'hF, 4'h0, 8'hAA, 8'hAA};
        vectors[2] = '{4'h0, 4'hF, 8'hFF, 8'h00};
        vectors[3] = '{4'h5, 4'h3, 8'h2D, 8'h22};
        vectors[4] = '{4'hC, 4'h9, 8'h63, 8'hA0};

        rst_n = 1'b0;
        ifA.in_valid = 0; ifA.cst = '0; ifA.rnd_valid = 0; ifA.rnd = '0; ifA.out_ready = 0;
        ifB.in_valid = 0; ifB.cst = '0; ifB.rnd_valid = 0; ifB.rnd = '0; ifB.out_ready = 1;
        ifC.in_valid = 0; ifC.cst = '0; ifC.rnd_valid = 0; ifC.rnd = '0; ifC.out_ready = 0;

        #2;
        checkOutput("rst_a_valid", 64'(ifA.out_valid), 64'd0);
        checkOutput("rst_a_out", 64'(ifA.out), 64'd0);
        checkOutput("rst_a_in_ready_nornd", 64'(ifA.in_ready), 64'd0);
        checkOutput("rst_b_in_ready", 64'(ifB.in_ready), 64'd1);
        checkOutput("rst_c_in_ready", 64'(ifC.in_ready), 64'd1);
        ifA.rnd_valid = 1'b1;
        #1;
        checkOutput("rst_a_in_ready_rnd", 64'(ifA.in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) applyStimulus(vectors[k]);
        ifA.in_valid = 1'b0; ifB.in_valid = 1'b0;
        tick();
        checkOutput("tbl_a_drained", 64'(ifA.out_valid), 64'd0);
        checkOutput("tbl_b_drained", 64'(ifB.out_valid), 64'd0);

        // Back-pressure: two words fill the buffer, the third must wait.
        r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom);
        ifA.out_ready = 1'b0; ifA.rnd_valid = 1'b1;
        ifA.in_valid = 1'b1; ifA.cst = 4'h1; ifA.rnd = r0;
        tick();
        ifA.cst = 4'h2; ifA.rnd = r1;
        tick();
        ifA.cst = 4'h3; ifA.rnd = r2;
        #1;
        checkOutput("bp_full_in_ready", 64'(ifA.in_ready), 64'd0);
        checkOutput("bp_full_rnd_ready", 64'(ifA.rnd_ready), 64'd0);
        tick();
        checkOutput("bp_hold_out", 64'(ifA.out), 64'(modelA(4'h1, r0)));
        ifA.out_ready = 1'b1;
        #1;
        checkOutput("bp_no_comb_path", 64'(ifA.in_ready), 64'd0);
        @(posedge clk); #1;
        checkOutput("bp_space_in_ready", 64'(ifA.in_ready), 64'd1);
        tick();
        ifA.in_valid = 1'b0;
        tick();
        tick();
        checkOutput("bp_empty", 64'(ifA.out_valid), 64'd0);
        checkOutput("bp_sb_drained", 64'(qA.size()), 64'd0);

        // Randomness starvation blocks the transfer but still requests rnd.
        ifA.in_valid = 1'b1; ifA.cst = 4'h3; ifA.rnd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("stall_in_ready", 64'(ifA.in_ready), 64'd0);
            checkOutput("stall_rnd_ready", 64'(ifA.rnd_ready), 64'd1);
            checkOutput("stall_valid", 64'(ifA.out_valid), 64'd0);
            @(posedge clk); #1;
        end
        ifA.rnd_valid = 1'b1; ifA.rnd = 4'h5;
        #1;
        checkOutput("stall_release_in_ready", 64'(ifA.in_ready), 64'd1);
        @(posedge clk); #1;
        ifA.in_valid = 1'b0; ifA.rnd_valid = 1'b0;
        checkOutput("stall_single_valid", 64'(ifA.out_valid), 64'd1);
        checkOutput("stall_single_out", 64'(ifA.out), 64'(modelA(4'h3, 4'h5)));
        tick();
        checkOutput("stall_single_gone", 64'(ifA.out_valid), 64'd0);

        // Reset while the buffer is full discards both words immediately.
        ifA.out_ready = 1'b0; ifA.rnd_valid = 1'b1;
        ifA.in_valid = 1'b1; ifA.cst = 4'h7; ifA.rnd = 4'($urandom);
        tick();
        ifA.cst = 4'h8; ifA.rnd = 4'($urandom);
        tick();
        ifA.in_valid = 1'b0;
        #1;
        checkOutput("mid_full_in_ready", 64'(ifA.in_ready), 64'd0);
        rst_n = 1'b0;
        qA.delete();
        #1;
        checkOutput("mid_rst_valid", 64'(ifA.out_valid), 64'd0);
        checkOutput("mid_rst_out", 64'(ifA.out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_post_empty", 64'(ifA.out_valid), 64'd0);
        tick();
        ifA.out_ready = 1'b1; ifA.in_valid = 1'b1; ifA.cst = 4'hC; ifA.rnd = 4'h9;
        tick();
        ifA.in_valid = 1'b0;
        checkOutput("mid_new_valid", 64'(ifA.out_valid), 64'd1);
        checkOutput("mid_new_out", 64'(ifA.out), 64'h63);
        tick();
        checkOutput("mid_new_gone", 64'(ifA.out_valid), 64'd0);

        // Single-share stream: out must equal cst, in order, under random stalls.
        for (int n = 0; n < 256; n++) begin
            cWord = 8'($urandom);
            ifC.in_valid = 1'b1; ifC.cst = cWord;
            ifC.rnd = 1'($urandom); ifC.rnd_valid = 1'($urandom);
            sent = 1'b0;
            for (int k = 0; k < 50 && !sent; k++) begin
                ifC.out_ready = 1'($urandom_range(0, 1));
                #1;
                sent = ifC.in_ready;
                checkOutput("c_rnd_ready", 64'(ifC.rnd_ready), 64'd0);
                @(posedge clk); #1;
            end
            checkOutput("c_send_timeout", 64'(sent), 64'd1);
        end
        ifC.in_valid = 1'b0; ifC.out_ready = 1'b1;
        for (int k = 0; k < 10 && qC.size() != 0; k++) tick();
        tick();
        checkOutput("c_drained", 64'(qC.size()), 64'd0);
        checkOutput("c_empty", 64'(ifC.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/msk_encode_pipe.md
# msk_encode_pipe

Registered, handshaked successor to the constant-masking primitive. Encodes a `count`-bit non-sensitive word into a `d`-share Boolean sharing, either trivially (value in the top share, zeros elsewhere) or with fresh randomness (uniform random sharing). It sits between public control/constant sources and the masked datapath. A two-entry output buffer lets it sustain one word per cycle under valid/ready back-pressure.

## Interface
- `d`, 2: number of shares, ≥1.
- `count`, 1: number of encoded bits per word, ≥1.
- `RANDOMIZE`, 1: 1 = random sharing from `rnd`; 0 = trivial sharing. Forced to trivial behaviour when `d`=1.

- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block accepts input this cycle.
- `cst`  in  `count`: non-sensitive word to encode.
- `rnd_valid`  in  1: randomness valid.
- `rnd_ready`  out  1: randomness consumed this cycle.
- `rnd`  in  `count*(d-1)` (min 1): fresh random bits; ignored when trivial.
- `out_valid`  out  1: sharing valid.
- `out_ready`  in  1: downstream accepts sharing.
- `out`  out  `count*d`: output sharing.

## Operation
- Share layout: bit i occupies `out[i*d +: d]`; share j is bit `i*d+j`; XOR of the d bits of group i equals `cst[i]`.
- Trivial encode: bit `i*d+d-1` = `cst[i]`, shares 0..d-2 = 0.
- Random encode (`RANDOMIZE`=1, d>1): share j<d-1 of group i = `rnd[i*(d-1)+j]`; share d-1 = `cst[i]` XOR all d-1 random bits of group i.
- `rnd_needed` = `RANDOMIZE` && d>1 (elaboration constant).
- `in_ready` = (occ<2) && (`rnd_valid` || !`rnd_needed`). Independent of `out_ready`; no combinational path out_ready→in_ready.
- `rnd_ready` = `rnd_needed` && `in_valid` && (occ<2). Randomness is consumed exactly on input transfers; tied 0 when not needed.
- Input transfer: `in_valid` && `in_ready`; encoded word pushed into buffer.
- Output transfer: `out_valid` && `out_ready`; head popped.
- Buffer: 2 entries, occ ∈ {0,1,2}; `out_valid` = occ≠0; `out` = head entry (registered, never combinational from `cst`/`rnd`).
- Simultaneous push and pop: occ unchanged; the pushed word queues behind the current head (occ=1 → new head next cycle); order strictly FIFO.
- occ=2: no push regardless of `out_ready` that cycle.
- `out` and `out_valid` hold stable while `out_valid` && !`out_ready`.
- Randomness bits are never reused: each accepted word uses the `rnd` sampled in its own transfer cycle.

## Timing
- Reset (async assert, sync-deasserted upstream): occ=0, `out_valid`=0, both buffer entries and `out`=0. `in_ready` after reset = `rnd_valid` || !`rnd_needed`.
- Latency: transfer at edge t → `out_valid`=1 with that word after edge t (visible cycle t+1).
- Throughput: 1 word/cycle with `out_ready` held high and `rnd_valid` high.
- Reset mid-operation: buffered words discarded, no partial output; outputs go to reset values immediately on `rst_n` low.
- `rnd_valid` low with `rnd_needed`: no input transfer, `rnd_ready`=0 unless `in_valid` and space (handshake waits on the rnd side); buffered words still drain.

## Structure
- Package `msk_pkg`: function `msk_encode_trivial(cst)` and `msk_encode_rand(cst, rnd)` parametrised via `d`/`count`, plus share-index helper `share_bit(i,j)` = i*d+j.
- Sub-module `msk_fifo2`: generic 2-entry valid/ready buffer of width `count*d`, async active-low reset, occ counter, head/tail pointer.
- Top: encode logic (combinational, from package) + handshake glue + `msk_fifo2`.

## Test plan
- d=2, count=4, RANDOMIZE=0, `cst`=4'b1010, `out_ready`=1 → next cycle `out`=8'h88, `out_valid`=1, `rnd_ready` constant 0.
- d=2, count=4, RANDOMIZE=1, `cst`=4'b1010, `rnd`=4'b0110, `rnd_valid`=1 → `rnd_ready`=1 in transfer cycle; next cycle `out`=8'hB4; per-group XOR = 1010.
- `out_ready`=0, three back-to-back `in_valid` words A,B,C → A,B accepted, `in_ready`=0 at occ=2, C held; raise `out_ready` → A, B, C emerged in order, no loss/duplication.
- RANDOMIZE=1, `rnd_valid`=0 for 3 cycles with `in_valid`=1 → no transfer, `in_ready`=0, occ unchanged; `rnd_valid`=1 → single transfer.
- Assert `rst_n`=0 at occ=2 mid-stream → same cycle `out_valid`=0, `out`=0; after release occ=0, first new word appears with 1-cycle latency.
- d=1, count=8, RANDOMIZE=1, stream 256 random words with random `out_ready` → `out`=`cst` per word in order, `rnd_ready`=0 always.
